// File: rtl/display_pkg.sv
// Shared register-window offsets and decode helper for the display capture stage.
package display_pkg;

    localparam logic [1:0] OFF_LO   = 2'd0;
    localparam logic [1:0] OFF_HI   = 2'd1;
    localparam logic [1:0] OFF_CTRL = 2'd2;
    localparam logic [1:0] OFF_RSVD = 2'd3;

    localparam int CTRL_AUTOCOUNT_BIT = 0;

    function automatic logic addr_in_window(input logic [15:0] addr, input logic [15:0] base);
        return addr[15:2] == base[15:2];
    endfunction

endpackage

// File: rtl/bus_strobe_sync.sv
// Synchronizes the raw CPU phi2 strobe into clk and flags its falling edge.
module bus_strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_phi2,
    output logic o_fall
);

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("bus_strobe_sync: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_phi2};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_fall = r_hist & ~r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/display_latch.sv
// CPU-mapped capture of the 16-bit seven-segment display word with atomic LO/HI staging.
// Optional free-running increment mode is built only when DISPLAY_AUTOCOUNT_EN is defined.
module display_latch
    import display_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'hD000,
    parameter int          SYNC_STAGES = 2,
    parameter int          TICK_WIDTH  = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_phi2,
    input  logic        cpu_rw,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    output logic [15:0] data,
    output logic        commit_pulse
);

    if (TICK_WIDTH < 1) begin : g_bad_tick
        $error("display_latch: TICK_WIDTH must be at least 1");
    end

    logic [15:0] r_smp_addr;
    logic        r_smp_rw;
    logic [7:0]  r_smp_data;
    logic [7:0]  r_shadow_lo;
    logic [15:0] r_data;
    logic        r_commit;

    logic w_fall;
    logic w_hit;
    logic w_wr_lo;
    logic w_wr_hi;
    logic w_wrap;

    bus_strobe_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_phi2 (cpu_phi2),
        .o_fall (w_fall)
    );

    // Sample is a pure data-path register: it only matters once a fall is seen.
    always_ff @(posedge clk) begin
        if (cpu_phi2) begin
            r_smp_addr <= cpu_addr;
            r_smp_rw   <= cpu_rw;
            r_smp_data <= cpu_data;
        end
    end

    assign w_hit   = w_fall & ~r_smp_rw & addr_in_window(r_smp_addr, BASE_ADDR);
    assign w_wr_lo = w_hit & (r_smp_addr[1:0] == OFF_LO);
    assign w_wr_hi = w_hit & (r_smp_addr[1:0] == OFF_HI);

`ifdef DISPLAY_AUTOCOUNT_EN
    logic                  r_autocount;
    logic [TICK_WIDTH-1:0] r_tick;
    logic                  w_wr_ctrl;

    assign w_wr_ctrl = w_hit & (r_smp_addr[1:0] == OFF_CTRL);
    assign w_wrap    = r_autocount & (r_tick == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_autocount <= 1'b0;
            r_tick      <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_autocount <= r_smp_data[CTRL_AUTOCOUNT_BIT];
            end
            if (!r_autocount) begin
                r_tick <= '0;
            end else begin
                r_tick <= r_tick + TICK_WIDTH'(1);
            end
        end
    end
`else
    assign w_wrap = 1'b0;
`endif

    // A CPU commit takes priority over a coincident autocount increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow_lo <= 8'h00;
            r_data      <= 16'h0000;
            r_commit    <= 1'b0;
        end else begin
            r_commit <= 1'b0;
            if (w_wr_lo) begin
                r_shadow_lo <= r_smp_data;
            end
            if (w_wr_hi) begin
                r_data   <= {r_smp_data, r_shadow_lo};
                r_commit <= 1'b1;
            end else if (w_wrap) begin
                r_data <= r_data + 16'd1;
            end
        end
    end

    assign data         = r_data;
    assign commit_pulse = r_commit;

endmodule

// File: tb/tb_display_latch.sv
// Directed self-checking bench for display_latch; autocount steps build with DISPLAY_AUTOCOUNT_EN.
module tb_display_latch;

   logic        clk;
   logic        rst_n;
   logic        cpu_phi2;
   logic        cpu_rw;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_data;
   logic [15:0] data;
   logic        commit_pulse;

   int n_cmp;
   int n_err;

   display_latch #(
      .BASE_ADDR   (16'hD000),
      .SYNC_STAGES (2),
      .TICK_WIDTH  (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cpu_phi2     (cpu_phi2),
      .cpu_rw       (cpu_rw),
      .cpu_addr     (cpu_addr),
      .cpu_data     (cpu_data),
      .data         (data),
      .commit_pulse (commit_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge just after t0+1.
   task automatic bus_cycle(input logic [15:0] a, input logic rw, input logic [7:0] d,
                            input int hi_len);
      cpu_addr = a;
      cpu_rw   = rw;
      cpu_data = d;
      cpu_phi2 = 1'b1;
      repeat (hi_len) @(negedge clk);
      cpu_phi2 = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      rst_n    = 1'b0;
      cpu_phi2 = 1'b0;
      cpu_rw   = 1'b1;
      cpu_addr = 16'h0000;
      cpu_data = 8'h00;

      // Reset with live bus traffic: a HI write must leave no trace.
      @(negedge clk);
      bus_cycle(16'hD001, 1'b0, 8'h55, 4);
      repeat (2) @(negedge clk);
      check("reset_data", data, 16'h0000);
      check("reset_commit", {15'd0, commit_pulse}, 16'h0000);
      rst_n = 1'b1;
      @(negedge clk);
      check("release_first_edge_data", data, 16'h0000);
      check("release_first_edge_commit", {15'd0, commit_pulse}, 16'h0000);
      repeat (4) @(negedge clk);
      check("release_settled_data", data, 16'h0000);

      // LO stages only.
      bus_cycle(16'hD000, 1'b0, 8'h34, 4);
      @(negedge clk);
      check("lo_write_data", data, 16'h0000);
      check("lo_write_commit", {15'd0, commit_pulse}, 16'h0000);
      repeat (3) @(negedge clk);

      // HI commits at t0+2, pulse exactly one cycle.
      bus_cycle(16'hD001, 1'b0, 8'h12, 4);
      check("hi_t0p1_data", data, 16'h0000);
      check("hi_t0p1_commit", {15'd0, commit_pulse}, 16'h0000);
      @(negedge clk);
      check("hi_t0p2_data", data, 16'h1234);
      check("hi_t0p2_commit", {15'd0, commit_pulse}, 16'h0001);
      @(negedge clk);
      check("hi_t0p3_commit", {15'd0, commit_pulse}, 16'h0000);
      check("hi_t0p3_data", data, 16'h1234);
      repeat (2) @(negedge clk);

      // Filtering: read, out-of-window, reserved, and CTRL with bit0 clear.
      bus_cycle(16'hD001, 1'b1, 8'hFF, 4);
      @(negedge clk);
      check("read_ignored_data", data, 16'h1234);
      check("read_ignored_commit", {15'd0, commit_pulse}, 16'h0000);
      repeat (3) @(negedge clk);
      bus_cycle(16'hD005, 1'b0, 8'hFF, 4);
      @(negedge clk);
      check("miss_d005_data", data, 16'h1234);
      check("miss_d005_commit", {15'd0, commit_pulse}, 16'h0000);
      repeat (3) @(negedge clk);
      bus_cycle(16'hD003, 1'b0, 8'hFF, 4);
      @(negedge clk);
      check("rsvd_d003_data", data, 16'h1234);
      repeat (3) @(negedge clk);
      bus_cycle(16'hD002, 1'b0, 8'hFE, 4);
      @(negedge clk);
      check("ctrl_d002_data", data, 16'h1234);
      check("ctrl_d002_commit", {15'd0, commit_pulse}, 16'h0000);
      repeat (3) @(negedge clk);

      // Shadow reuse.
      bus_cycle(16'hD001, 1'b0, 8'hAB, 4);
      @(negedge clk);
      check("shadow_reuse_data", data, 16'hAB34);
      check("shadow_reuse_commit", {15'd0, commit_pulse}, 16'h0001);
      repeat (3) @(negedge clk);

      // Back-to-back LO then HI.
      bus_cycle(16'hD000, 1'b0, 8'hCD, 4);
      @(negedge clk);
      bus_cycle(16'hD001, 1'b0, 8'hEF, 4);
      @(negedge clk);
      check("b2b_data", data, 16'hEFCD);
      check("b2b_commit", {15'd0, commit_pulse}, 16'h0001);
      repeat (3) @(negedge clk);

      // Reset between the phi2 fall and t0+2 discards the strobe.
      bus_cycle(16'hD001, 1'b0, 8'h11, 4);
      rst_n = 1'b0;
      @(negedge clk);
      check("midreset_data", data, 16'h0000);
      check("midreset_commit", {15'd0, commit_pulse}, 16'h0000);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("midreset_after_data", data, 16'h0000);
      check("midreset_after_commit", {15'd0, commit_pulse}, 16'h0000);
      bus_cycle(16'hD001, 1'b0, 8'h22, 4);
      @(negedge clk);
      check("post_reset_hi_data", data, 16'h2200);
      repeat (3) @(negedge clk);

`ifdef DISPLAY_AUTOCOUNT_EN
      bus_cycle(16'hD000, 1'b0, 8'hFF, 4);
      @(negedge clk);
      bus_cycle(16'hD001, 1'b0, 8'hFF, 4);
      @(negedge clk);
      check("auto_preset_data", data, 16'hFFFF);
      repeat (3) @(negedge clk);
      // Enable lands on edge E; wraps at E+16, E+32, ...
      bus_cycle(16'hD002, 1'b0, 8'h01, 4);
      @(negedge clk);
      repeat (15) @(negedge clk);
      check("auto_e15_data", data, 16'hFFFF);
      @(negedge clk);
      check("auto_e16_data", data, 16'h0000);
      check("auto_e16_commit", {15'd0, commit_pulse}, 16'h0000);
      repeat (16) @(negedge clk);
      check("auto_e32_data", data, 16'h0001);
      // High length 13 puts the HI commit exactly on the E+48 wrap.
      bus_cycle(16'hD001, 1'b0, 8'h80, 13);
      @(negedge clk);
      check("auto_collide_data", data, 16'h80FF);
      check("auto_collide_commit", {15'd0, commit_pulse}, 16'h0001);
      repeat (16) @(negedge clk);
      check("auto_e64_data", data, 16'h8100);
      bus_cycle(16'hD002, 1'b0, 8'h00, 4);
      repeat (20) @(negedge clk);
      check("auto_off_data", data, 16'h8100);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/display_latch.md
# display_latch

Memory-mapped capture stage that feeds the 4-digit multiplexed seven-segment driver with its 16-bit `data` word. It decodes 65C02 bus writes to a small register window, synchronizes the asynchronous CPU strobe into the `clk` domain, and stages the low byte so the displayed 16-bit value changes atomically. Its `data` output connects directly to the display driver's `data` input.

## Interface
- `BASE_ADDR`, default 16'hD000: window base; bits [1:0] ignored (4-byte aligned).
- `SYNC_STAGES`, default 2: flops in the `cpu_phi2` synchronizer; minimum 2.
- `TICK_WIDTH`, default 20: autocount prescaler width (only used with `DISPLAY_AUTOCOUNT_EN`).
- `clk` in 1: system clock; at least 4× the `cpu_phi2` frequency.
- `rst_n` in 1: asynchronous, active-low reset.
- `cpu_phi2` in 1: raw CPU phase-2 clock, asynchronous to `clk`.
- `cpu_rw` in 1: CPU read/write (1 = read, 0 = write).
- `cpu_addr` in 16: CPU address bus.
- `cpu_data` in 8: CPU data bus.
- `data` out 16: displayed value, to the display driver.
- `commit_pulse` out 1: single-cycle strobe, high in the cycle `data` takes a CPU-committed value.

## Operation
- Bus sample: on every `clk` edge where raw `cpu_phi2`=1, latch `cpu_addr`, `cpu_rw` and `cpu_data` into a holding register. While raw `cpu_phi2`=0, the sample is frozen.
- Strobe: `cpu_phi2` passes through `SYNC_STAGES` flops, plus one history flop. A fall (synced=0, history=1) marks the end of a CPU cycle and acts on the frozen sample.
- Decode: hit when sample addr[15:2] == `BASE_ADDR`[15:2] and rw=0. Reads and misses have no effect.
- Offset 0 (LO): `shadow_lo` <= sample data. `data` is unchanged.
- Offset 1 (HI): `data` <= {sample data, `shadow_lo`}; `commit_pulse`=1 for one cycle. `shadow_lo` is retained, so repeated HI writes reuse it.
- Offset 2 (CTRL): bit0 = `autocount`; the other bits are ignored. Only exists with the macro; otherwise the write is ignored.
- Offset 3: reserved, write ignored.
- Reset values: `data`=0, `shadow_lo`=0, `ctrl`=0, `commit_pulse`=0. All sync and history flops reset to 0, so no spurious fall is detected after reset.
- Reset mid-operation: an in-flight strobe is discarded. The first fall after release requires a full phi2 high period to be seen by the synchronizer.

## Timing
- Let t0 be the first `clk` edge sampling raw `cpu_phi2`=0. `data` and `commit_pulse` update at edge t0+`SYNC_STAGES` (t0+2 by default).
- `shadow_lo` updates on the same edge for LO writes.
- Back-to-back CPU cycles: each fall is handled independently. At most one action per fall, so LO followed by HI in consecutive CPU cycles commits correctly.
- `commit_pulse` is registered, exactly 1 cycle wide, never asserted without a `data` change source.

## Configuration
- `DISPLAY_AUTOCOUNT_EN` defined:
  - CTRL register and a `TICK_WIDTH`-bit prescaler are present.
  - While `autocount`=1, the prescaler counts every `clk`; on wrap to 0, `data` <= `data`+1 (16-bit, FFFF→0000).
  - Prescaler holds at 0 while `autocount`=0.
  - A CPU HI commit in the same cycle as a wrap wins; that increment is dropped.
  - Autocount increments do not assert `commit_pulse`.
- Not defined: no CTRL register, no prescaler; offset 2 behaves like offset 3.

## Structure
- Package `display_pkg`: offset constants `OFF_LO`=0, `OFF_HI`=1, `OFF_CTRL`=2, and `CTRL_AUTOCOUNT_BIT`=0.
- Sub-module `bus_strobe_sync`: parameterized `SYNC_STAGES` synchronizer plus history flop. Outputs the `fall` pulse; reset is async active-low.
- Decode, shadow, output register and prescaler live in `display_latch`.

## Test plan
- Reset: hold `rst_n`=0 with bus toggling → `data`=0000, `commit_pulse`=0; no update on the first edge after release.
- Atomic write: LO write 8'h34 then HI write 8'h12 at D000/D001 → `data`=0000 after LO, 1234 at t0+2 of the HI cycle, `commit_pulse` high exactly 1 cycle.
- Filtering:
  - Read cycle at D001 with data 8'hFF → `data` unchanged.
  - Write to D005 → ignored.
  - Write to D003 → ignored.
- Shadow reuse: after 1234, HI write 8'hAB → `data`=AB34.
- Autocount (macro on, `TICK_WIDTH`=4):
  - Write CTRL=01 with `data`=FFFF → `data`=0000 after 16 clocks, 0001 after 32.
  - Force a HI commit coincident with a wrap → commit value kept, no increment.
- Mid-strobe reset: assert `rst_n` during phi2 low before t0+2 → no `data` change and no `commit_pulse`.
